// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states,
// iteration count and op-class helper.
package mdu_pkg;

  localparam int ITER = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;

  // Even codes of the arithmetic group are the signed variants.
  function automatic logic is_signed_op(input logic [2:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_step_core.sv
// One radix-2 iteration on the 2*WIDTH working register: shift-add multiply or
// restoring shift-subtract divide. Purely combinational.
module mdu_step_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = ITER
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     operand_b,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] diff_s;

  // Multiply keeps the product in the upper half and shifts multiplier bits out of
  // the lower half; divide shifts dividend bits into the remainder in the upper half.
  always_comb begin
    sum_s    = {1'b0, acc[2*WIDTH-1:WIDTH]}
               + (acc[0] ? {1'b0, operand_b} : {(WIDTH+1){1'b0}});
    diff_s   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand_b};
    acc_next = {2*WIDTH{1'b0}};
    if (is_div) begin
      if (diff_s[WIDTH]) begin
        acc_next = {acc[2*WIDTH-2:0], 1'b0};
      end else begin
        acc_next = {diff_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_next = {sum_s, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning architectural HI/LO; 33-cycle latency for
// MULT/MULTU/DIV/DIVU, single-edge MTHI/MTLO.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = ITER,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};

  mdu_state_e         state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   b_r;
  logic               is_div_r;
  logic               sign_a_r;
  logic               sign_b_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               done_r;

  logic               neg_a_s;
  logic               neg_b_s;
  logic [WIDTH-1:0]   abs_a_s;
  logic [WIDTH-1:0]   abs_b_s;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   fix_hi_s;
  logic [WIDTH-1:0]   fix_lo_s;

  mdu_step_core #(.WIDTH(WIDTH)) u_step (
    .is_div    (is_div_r),
    .acc       (acc_r),
    .operand_b (b_r),
    .acc_next  (acc_next_s)
  );

  // Operand magnitudes at accept; 0x80000000 stays 2^31 as an unsigned magnitude.
  always_comb begin
    neg_a_s = is_signed_op(op) && rs_data[WIDTH-1];
    neg_b_s = is_signed_op(op) && rt_data[WIDTH-1];
    abs_a_s = neg_a_s ? (ZERO_W - rs_data) : rs_data;
    abs_b_s = neg_b_s ? (ZERO_W - rt_data) : rt_data;
  end

  // Sign fixup; with a zero divisor the remainder path already rebuilds the raw dividend.
  always_comb begin
    prod_s   = (sign_a_r ^ sign_b_r) ? ({2*WIDTH{1'b0}} - acc_r) : acc_r;
    quot_s   = (sign_a_r ^ sign_b_r) ? (ZERO_W - acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
    rem_s    = sign_a_r ? (ZERO_W - acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
    fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
    fix_lo_s = prod_s[WIDTH-1:0];
    if (is_div_r) begin
      fix_hi_s = rem_s;
      if (b_r == ZERO_W) begin
        fix_lo_s = {WIDTH{1'b1}};
      end else begin
        fix_lo_s = quot_s;
      end
    end else begin
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM, iteration counter, working registers and HI/LO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      acc_r    <= {2*WIDTH{1'b0}};
      b_r      <= ZERO_W;
      is_div_r <= 1'b0;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      hi_r     <= ZERO_W;
      lo_r     <= ZERO_W;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // The done cycle still reports busy, so requests there are dropped too.
          if (start && !done_r) begin
            case (op)
              MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                acc_r    <= {ZERO_W, abs_a_s};
                b_r      <= abs_b_s;
                sign_a_r <= neg_a_s;
                sign_b_r <= neg_b_s;
                is_div_r <= op[1];
                cnt_r    <= {CNT_W{1'b0}};
                state_r  <= RUN;
              end
              MDU_MTHI: hi_r <= rs_data;
              MDU_MTLO: lo_r <= rs_data;
              default: ;
            endcase
          end
        end
        RUN: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_STEP) begin
            state_r <= FIX;
          end
        end
        FIX: begin
          hi_r    <= fix_hi_s;
          lo_r    <= fix_lo_s;
          done_r  <= 1'b1;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign hi   = hi_r;
  assign lo   = lo_r;
  assign done = done_r;
  assign busy = (state_r != IDLE) || done_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus randomized
// operations against a plain-arithmetic reference model.
module tb_mul_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  mul_div_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference results from ordinary 64-bit arithmetic.
  function automatic void model(input logic [2:0] o, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] h,
                                output logic [31:0] l);
    longint      sa, sb, p, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h  = 32'h0;
    l  = 32'h0;
    case (o)
      3'b000: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      3'b001: begin u = {32'h0, a} * {32'h0, b}; h = u[63:32]; l = u[31:0]; end
      3'b010: begin
        if (b == 32'h0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin p = sa / sb; r = sa % sb; h = r[31:0]; l = p[31:0]; end
      end
      3'b011: begin
        if (b == 32'h0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin h = a % b; l = a / b; end
      end
      default: begin h = 32'h0; l = 32'h0; end
    endcase
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one iterative op and watch 40 cycles; optionally pulse a stray start at 'inject'.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inject, input string name);
    logic [31:0] eh, el, ph, pl;
    int nb, nd, first;
    bit held;
    model(o, a, b, eh, el);
    ph = hi; pl = lo; nb = 0; nd = 0; first = -1; held = 1'b1;
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    cycle();
    for (int k = 0; k < 40; k++) begin
      if (k == inject) begin
        start = 1'b1; op = 3'b000; rs_data = $urandom; rt_data = $urandom;
      end else begin
        start = 1'b0; op = 3'($urandom); rs_data = $urandom; rt_data = $urandom;
      end
      if (busy) nb++;
      if (done) begin
        nd++;
        if (first < 0) first = k;
      end
      if (k < 33 && (hi !== ph || lo !== pl)) held = 1'b0;
      cycle();
    end
    start = 1'b0;
    checks += 6;
    if (first !== 33) begin errors++; $display("FAIL %s_latency got %0d exp 33", name, first); end
    if (nd !== 1) begin errors++; $display("FAIL %s_done_cycles got %0d exp 1", name, nd); end
    if (nb !== 34) begin errors++; $display("FAIL %s_busy_cycles got %0d exp 34", name, nb); end
    if (held !== 1'b1) begin errors++; $display("FAIL %s_hilo_held got changed exp stable", name); end
    if (hi !== eh) begin errors++; $display("FAIL %s_hi got %h exp %h", name, hi, eh); end
    if (lo !== el) begin errors++; $display("FAIL %s_lo got %h exp %h", name, lo, el); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 3'b000; rs_data = 32'h0; rt_data = 32'h0;
    cycle(); cycle();
    checks += 4;
    if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
    if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_directed();
    run_op(3'b000, 32'hFFFF_FFFD, 32'd5, -1, "mult_neg");
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "multu_max");
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, -1, "div_neg");
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_ovf");
    run_op(3'b011, 32'd7, 32'd0, -1, "divu_zero");
    run_op(3'b010, 32'hFFFF_FFF9, 32'd0, -1, "div_zero_neg");
  endtask

  task automatic test_move();
    logic [31:0] v, h0, l0;
    start = 1'b1; op = 3'b100; rs_data = 32'h1234;
    cycle();
    start = 1'b0;
    checks += 3;
    if (hi !== 32'h1234) begin errors++; $display("FAIL mthi_hi got %h exp 00001234", hi); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b exp 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL mthi_done got %b exp 0", done); end
    v = $urandom;
    start = 1'b1; op = 3'b101; rs_data = v;
    cycle();
    start = 1'b0;
    checks += 3;
    if (lo !== v) begin errors++; $display("FAIL mtlo_lo got %h exp %h", lo, v); end
    if (hi !== 32'h1234) begin errors++; $display("FAIL mtlo_hi got %h exp 00001234", hi); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy got %b exp 0", busy); end
    h0 = hi; l0 = lo;
    for (int k = 6; k < 8; k++) begin
      start = 1'b1; op = 3'(k); rs_data = ~v; rt_data = $urandom;
      cycle();
      start = 1'b0;
      checks += 3;
      if (hi !== h0) begin errors++; $display("FAIL noop%0d_hi got %h exp %h", k, hi, h0); end
      if (lo !== l0) begin errors++; $display("FAIL noop%0d_lo got %h exp %h", k, lo, l0); end
      if (busy !== 1'b0) begin errors++; $display("FAIL noop%0d_busy got %b exp 0", k, busy); end
    end
  endtask

  task automatic test_start_while_busy();
    run_op(3'b011, 32'd100, 32'd7, 5, "busy_ignore");
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(o, a, b, -1, $sformatf("rand%0d_op%0d", i, o));
    end
  endtask

  task automatic test_midop_reset();
    int seen_done, seen_busy;
    start = 1'b1; op = 3'b100; rs_data = $urandom | 32'h1;
    cycle();
    op = 3'b101; rs_data = $urandom | 32'h1;
    cycle();
    op = 3'b000; rs_data = $urandom; rt_data = $urandom;
    cycle();
    start = 1'b0;
    for (int k = 1; k < 10; k++) cycle();
    rst_n = 1'b0;
    cycle();
    checks += 3;
    if (hi !== 32'h0) begin errors++; $display("FAIL midrst_hi got %h exp 0", hi); end
    if (lo !== 32'h0) begin errors++; $display("FAIL midrst_lo got %h exp 0", lo); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    rst_n = 1'b1;
    seen_done = 0; seen_busy = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) seen_done++;
      if (busy) seen_busy++;
      cycle();
    end
    checks += 4;
    if (seen_done !== 0) begin errors++; $display("FAIL midrst_done got %0d pulses exp 0", seen_done); end
    if (seen_busy !== 0) begin errors++; $display("FAIL midrst_busy_after got %0d exp 0", seen_busy); end
    if (hi !== 32'h0) begin errors++; $display("FAIL midrst_hi_after got %h exp 0", hi); end
    if (lo !== 32'h0) begin errors++; $display("FAIL midrst_lo_after got %h exp 0", lo); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_move();
    test_start_while_busy();
    test_random();
    test_midop_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
